// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences each instruction through IF/ID/EX/MEM/WB
// states and drives the datapath mux selects and write enables.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       zero,
    input  logic       ge0,
    input  logic       mem_ready,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUOp,
    output logic [1:0] ExtOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EX  = 4'd2,
        S_MA  = 4'd3,
        S_MR  = 4'd4,
        S_MWB = 4'd5,
        S_MW  = 4'd6,
        S_WB  = 4'd7,
        S_BR  = 4'd8,
        S_JP  = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_ADDU, C_SUBU, C_SLT, C_JR, C_ORI, C_LUI,
        C_LW, C_SW, C_BEQ, C_BGEZAL, C_JAL
    } cls_t;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d, cls_dec;

    logic [1:0] reg_dst_c, mem_to_reg_c, alu_op_c, ext_op_c, pc_src_c;
    logic       alu_src_c, pc_write_c, ir_write_c, reg_write_c;
    logic       mem_read_c, mem_write_c, retire_c, illegal_c;

    always_comb begin
        cls_dec = C_NONE;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001: cls_dec = C_ADDU;
                    6'b100011: cls_dec = C_SUBU;
                    6'b101010: cls_dec = C_SLT;
                    6'b001000: cls_dec = C_JR;
                    default:   cls_dec = C_NONE;
                endcase
            end
            6'b000001: cls_dec = (rt == 5'b10001) ? C_BGEZAL : C_NONE;
            6'b001101: cls_dec = C_ORI;
            6'b001111: cls_dec = C_LUI;
            6'b100011: cls_dec = C_LW;
            6'b101011: cls_dec = C_SW;
            6'b000100: cls_dec = C_BEQ;
            6'b000011: cls_dec = C_JAL;
            default:   cls_dec = C_NONE;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        reg_dst_c    = 2'b00;
        alu_src_c    = 1'b0;
        mem_to_reg_c = 2'b00;
        alu_op_c     = 2'b00;
        ext_op_c     = 2'b00;
        pc_src_c     = 2'b00;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        retire_c     = 1'b0;
        illegal_c    = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_ID;
                end
            end
            S_ID: begin
                // Only this state looks at the live IR fields; later states use cls_q.
                cls_d = cls_dec;
                case (cls_dec)
                    C_ADDU, C_SUBU, C_SLT, C_ORI, C_LUI: state_d = S_EX;
                    C_LW, C_SW:                          state_d = S_MA;
                    C_BEQ, C_BGEZAL:                     state_d = S_BR;
                    C_JAL, C_JR:                         state_d = S_JP;
                    default: begin
                        state_d   = S_IF;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_EX: begin
                case (cls_q)
                    C_SUBU, C_SLT: alu_op_c = 2'b01;
                    C_ORI: begin
                        alu_op_c  = 2'b10;
                        alu_src_c = 1'b1;
                    end
                    C_LUI: begin
                        alu_op_c  = 2'b11;
                        alu_src_c = 1'b1;
                    end
                    default: alu_op_c = 2'b00;
                endcase
                state_d = S_WB;
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                reg_dst_c    = (cls_q == C_ORI || cls_q == C_LUI) ? 2'b00 : 2'b01;
                mem_to_reg_c = (cls_q == C_SLT) ? 2'b11 : 2'b00;
                state_d      = S_IF;
            end
            S_MA: begin
                alu_src_c = 1'b1;
                ext_op_c  = 2'b01;
                state_d   = (cls_q == C_SW) ? S_MW : S_MR;
            end
            S_MR: begin
                mem_read_c = 1'b1;
                if (mem_ready) state_d = S_MWB;
            end
            S_MWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 2'b01;
                retire_c     = 1'b1;
                state_d      = S_IF;
            end
            S_MW: begin
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_IF;
                end
            end
            S_BR: begin
                alu_op_c = 2'b01;
                pc_src_c = 2'b01;
                retire_c = 1'b1;
                if (cls_q == C_BGEZAL) begin
                    // Link register is written whether or not the branch is taken.
                    pc_write_c   = ge0;
                    reg_write_c  = 1'b1;
                    reg_dst_c    = 2'b10;
                    mem_to_reg_c = 2'b10;
                end else begin
                    pc_write_c = zero;
                end
                state_d = S_IF;
            end
            S_JP: begin
                pc_write_c = 1'b1;
                retire_c   = 1'b1;
                if (cls_q == C_JAL) begin
                    pc_src_c     = 2'b10;
                    reg_write_c  = 1'b1;
                    reg_dst_c    = 2'b10;
                    mem_to_reg_c = 2'b10;
                end else begin
                    pc_src_c = 2'b11;
                end
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IF;
            cls_q   <= C_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // Reset gates every output combinationally so an in-flight write dies without a clock.
    always_comb begin
        RegDst   = reset_n ? reg_dst_c    : 2'b00;
        ALUSrc   = reset_n ? alu_src_c    : 1'b0;
        MemtoReg = reset_n ? mem_to_reg_c : 2'b00;
        ALUOp    = reset_n ? alu_op_c     : 2'b00;
        ExtOp    = reset_n ? ext_op_c     : 2'b00;
        PCSrc    = reset_n ? pc_src_c     : 2'b00;
        PCWrite  = reset_n ? pc_write_c   : 1'b0;
        IRWrite  = reset_n ? ir_write_c   : 1'b0;
        RegWrite = reset_n ? reg_write_c  : 1'b0;
        MemRead  = reset_n ? mem_read_c   : 1'b0;
        MemWrite = reset_n ? mem_write_c  : 1'b0;
        retire   = reset_n ? retire_c     : 1'b0;
        illegal  = reset_n ? illegal_c    : 1'b0;
        state    = state_q;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the MIPS datapath. Sequences one instruction at a time through fetch, decode, execute, memory and write-back states. Drives the select lines of the register-destination, ALU-B and write-back multiplexers plus all datapath write enables. Sits between the instruction register fields and the shared ALU, register file, PC and single-ported memory.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- rt  in  5  IR[20:16]; distinguishes bgezal (rt=10001)
- zero  in  1  ALU result == 0
- ge0  in  1  register rs value >= 0 (sign bit clear)
- mem_ready  in  1  memory completes the current access this cycle
- RegDst  out  2  00 rt, 01 rd, 10 r31
- ALUSrc  out  1  0 RD2, 1 extended immediate
- MemtoReg  out  2  00 ALU result, 01 read data, 10 PC link, 11 {31'b0, less}
- ALUOp  out  2  00 add, 01 sub, 10 or, 11 lui (imm<<16)
- ExtOp  out  2  00 zero-extend, 01 sign-extend
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite  out  1 each  datapath enables
- retire  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse when an undecoded instruction is dropped
- state  out  4  current state code, for debug

## Operation
- Instruction classes: R (addu 100001, subu 100011, slt 101010), JR (funct 001000), ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, JAL 000011, BGEZAL (op 000001, rt 10001). R and JR use op 000000.
- In ID, the class is latched into an internal register. All later states decode outputs from state and the latched class only.
- States and transitions:
  - IF(0): MemRead=1. When mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=00, then go to ID. Otherwise hold in IF.
  - ID(1): R/ORI/LUI go to EX. LW/SW go to MA. BEQ/BGEZAL go to BR. JAL/JR go to JP. Any other encoding goes to IF with illegal=1.
  - EX(2): ALUOp = add (addu), sub (subu/slt), or (ORI), lui (LUI). ALUSrc=1 for ORI/LUI. ExtOp=00. Next state WB.
  - WB(7): RegWrite=1, retire=1. RegDst=01 for R, 00 for ORI/LUI. MemtoReg=11 for slt, else 00. Next state IF.
  - MA(3): ALUSrc=1, ExtOp=01, ALUOp=add. LW goes to MR, SW goes to MW.
  - MR(4): MemRead=1. Go to MWB on mem_ready, otherwise hold.
  - MWB(5): RegWrite=1, RegDst=00, MemtoReg=01, retire=1. Next state IF.
  - MW(6): MemWrite=1 for every cycle in the state. When mem_ready=1: retire=1, go to IF.
  - BR(8): ALUOp=sub, PCSrc=01, retire=1. BEQ: PCWrite=zero. BGEZAL: PCWrite=ge0; RegWrite=1, RegDst=10, MemtoReg=10 (link is written regardless of the branch outcome). Next state IF.
  - JP(9): PCWrite=1, retire=1. JAL: PCSrc=10, RegWrite=1, RegDst=10, MemtoReg=10. JR: PCSrc=11. Next state IF.
- Any output not listed for a state is 0.
- Codes 10 through 15 are unreachable. If reached, the FSM returns to IF on the next edge with all enables 0.

## Timing
- While reset_n=0: state=IF, class register cleared, and every output is forced to 0 combinationally, including IRWrite/MemRead in IF.
- Reset asserted mid-instruction aborts it immediately. A pending MemWrite or RegWrite deasserts in the same cycle, with no clock edge needed.
- After reset_n rises, the first fetch begins in the first cycle.
- Latency with mem_ready held at 1: R/ORI/LUI 4 cycles, LW 5, SW 4, BEQ/BGEZAL/JAL/JR 3, illegal 2. Each cycle mem_ready is low in IF/MR/MW adds exactly one cycle.
- All state changes occur on the rising edge of clk.
- retire and illegal are never high at the same time, and each is high for at most one cycle per instruction.

## Test plan
- Reset with reset_n=0 held across 3 edges: all outputs 0, state=0. One cycle after release: MemRead=1; IRWrite=1 only while mem_ready=1.
- addu (op 0, funct 100001), mem_ready=1: state sequence 0,1,2,7. In state 7: RegWrite=1, RegDst=01, MemtoReg=00, retire=1. Total 4 cycles.
- lw with mem_ready low for 2 cycles in MR: sequence 0,1,3,4,4,4,5. In state 5: MemtoReg=01, RegDst=00, RegWrite=1. Total 7 cycles.
- beq, once with zero=0 and once with zero=1: in state 8, PCWrite follows zero and PCSrc=01. bgezal with ge0=0: PCWrite=0, RegWrite=1, RegDst=10, MemtoReg=10.
- jal then jr: state 9 for each. PCSrc=10 with RegWrite=1 for jal; PCSrc=11 with RegWrite=0 for jr.
- sw stalled in MW, with reset_n pulled low during the stall: MemWrite drops to 0 in the same cycle. After release, state=0. Op 111111 produces illegal=1 in ID, then state returns to 0.
